rr_arbiter4: RTL and testbench

// - Round-robin arbiter that shares one resource between 4 requesters.
// - Winner is held as a 2-bit index and decoded to a one-hot grant (2-to-4 decode: idx 0->gnt[0] ... idx 3->gnt[3]).
// - Sits in front of the shared resource; each requester holds req high for the whole access.

---
 rtl/rr_arbiter4.sv | 119 +++++++++++
 tb/tb_rr_arbiter4.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with a registered one-hot grant.
// The winner is held as a 2-bit index and decoded to gnt. A request keeps its
// grant for as long as it stays high, and a grant is always followed by at
// least one idle cycle. Priority rotates to the requester after the one just
// released.
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// grant cycles, with a one-cycle timeout pulse on the forced release.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_gntIdx;
   logic [3:0] r_gnt;
   logic       r_gntValid;
   logic [1:0] w_winIdx;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] r_holdCnt;
   logic             r_timeout;
`endif

   // Reject parameter sets where the hold counter cannot reach MAX_HOLD-1.
   if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_badParams
      $error("rr_arbiter4: MAX_HOLD must be 2..255 and below 2**CNT_W");
   end

   // Pick the first requester at or after the pointer; scanning downwards
   // lets the closest candidate to the pointer overwrite the farther ones.
   always_comb begin
      w_winIdx = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (req[r_ptr + 2'(k)]) begin
            w_winIdx = r_ptr + 2'(k);
         end
      end
   end

   // Two-state arbitration machine; all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= 2'd0;
         r_gntIdx   <= 2'd0;
         r_gnt      <= 4'b0000;
         r_gntValid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_holdCnt  <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_gnt      <= 4'b0001 << w_winIdx;
                  r_gntIdx   <= w_winIdx;
                  r_gntValid <= 1'b1;
                  r_state    <= GRANT;
`ifdef ARB_TIMEOUT_EN
                  r_holdCnt  <= '0;
`endif
               end
            end
            GRANT: begin
               if (!req[r_gntIdx]) begin
                  r_gnt      <= 4'b0000;
                  r_gntIdx   <= 2'd0;
                  r_gntValid <= 1'b0;
                  r_ptr      <= r_gntIdx + 2'd1;
                  r_state    <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (r_holdCnt == CNT_W'(MAX_HOLD - 1)) begin
                  r_gnt      <= 4'b0000;
                  r_gntIdx   <= 2'd0;
                  r_gntValid <= 1'b0;
                  r_ptr      <= r_gntIdx + 2'd1;
                  r_state    <= IDLE;
                  r_timeout  <= 1'b1;
               end else begin
                  r_holdCnt  <= r_holdCnt + 1'b1;
               end
`endif
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_gntIdx;
   assign gnt_valid = r_gntValid;
`ifdef ARB_TIMEOUT_EN
   assign timeout   = r_timeout;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4: a vector table for single-cycle arbitration
// behaviour, plus hand-written sequences for rotation, reset during a grant
// and long holds (timeout pattern when ARB_TIMEOUT_EN is defined).
module tb_rr_arbiter4;

`ifdef ARB_TIMEOUT_EN
   localparam int MAX_HOLD = 4;
`else
   localparam int MAX_HOLD = 16;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic       tmo;
   } expect_t;

   typedef struct packed {
      logic [3:0] req;
      expect_t    exp;
   } vector_t;

   expect_t scoreboard[$];
   vector_t vectors[21];

   rr_arbiter4 #(
      .MAX_HOLD(MAX_HOLD),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .gnt(gnt),
      .gnt_idx(gnt_idx),
      .gnt_valid(gnt_valid),
      .timeout(timeout)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic expect_t ex(input logic [3:0] g, input logic [1:0] i, input logic t);
      expect_t e;
      e.gnt   = g;
      e.idx   = i;
      e.valid = (g != 4'b0000);
      e.tmo   = t;
      return e;
   endfunction

   task automatic checkOutput(input string name, input expect_t e);
      checkCount++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || timeout !== e.tmo) begin
         errorCount++;
         $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
                  name, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.tmo);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle of requests, queue the expectation, compare after the edge.
   task automatic applyStimulus(input string name, input logic [3:0] r, input expect_t e);
      expect_t popped;
      @(negedge clk);
      req = r;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      popped = scoreboard.pop_front();
      checkOutput(name, popped);
   endtask

   task automatic resetDut(input logic [3:0] r);
      req   = r;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b1;
   endtask

   initial begin
      int         grantsSeen;
      int         gapCount;
      int         holdCount;
      int         curIdx;
      int         expIdx[$];
      logic       prevValid;
      logic [3:0] g;
      int         p;
      int         n;

      vectors[0]  = '{4'b0100, ex(4'b0100, 2'd2, 1'b0)};
      vectors[1]  = '{4'b0100, ex(4'b0100, 2'd2, 1'b0)};
      vectors[2]  = '{4'b0100, ex(4'b0100, 2'd2, 1'b0)};
      vectors[3]  = '{4'b0000, ex(4'b0000, 2'd0, 1'b0)};
      vectors[4]  = '{4'b1001, ex(4'b1000, 2'd3, 1'b0)};
      vectors[5]  = '{4'b1001, ex(4'b1000, 2'd3, 1'b0)};
      vectors[6]  = '{4'b0011, ex(4'b0000, 2'd0, 1'b0)};
      vectors[7]  = '{4'b0011, ex(4'b0001, 2'd0, 1'b0)};
      vectors[8]  = '{4'b0011, ex(4'b0001, 2'd0, 1'b0)};
      vectors[9]  = '{4'b1010, ex(4'b0000, 2'd0, 1'b0)};
      vectors[10] = '{4'b1010, ex(4'b0010, 2'd1, 1'b0)};
      vectors[11] = '{4'b1010, ex(4'b0010, 2'd1, 1'b0)};
      vectors[12] = '{4'b1000, ex(4'b0000, 2'd0, 1'b0)};
      vectors[13] = '{4'b0001, ex(4'b0001, 2'd0, 1'b0)};
      vectors[14] = '{4'b0101, ex(4'b0001, 2'd0, 1'b0)};
      vectors[15] = '{4'b0100, ex(4'b0000, 2'd0, 1'b0)};
      vectors[16] = '{4'b0000, ex(4'b0000, 2'd0, 1'b0)};
      vectors[17] = '{4'b0110, ex(4'b0010, 2'd1, 1'b0)};
      vectors[18] = '{4'b0110, ex(4'b0010, 2'd1, 1'b0)};
      vectors[19] = '{4'b0100, ex(4'b0000, 2'd0, 1'b0)};
      vectors[20] = '{4'b0100, ex(4'b0100, 2'd2, 1'b0)};

      // Reset with every requester asserting.
      req   = 4'b1111;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("reset", ex(4'b0000, 2'd0, 1'b0));
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b1;

      // Table: single request, wrap, skip, lost pulse, same-requester gap.
      for (int i = 0; i < 21; i++) begin
         applyStimulus($sformatf("vector%0d", i), vectors[i].req, vectors[i].exp);
      end

      // Rotation: all request, each grantee drops 3 cycles after its grant.
      resetDut(4'b0000);
      expIdx     = '{0, 1, 2, 3, 0};
      grantsSeen = 0;
      gapCount   = 0;
      holdCount  = 0;
      curIdx     = 0;
      prevValid  = 1'b0;
      for (int c = 0; c < 60 && expIdx.size() > 0; c++) begin
         @(negedge clk);
         if (holdCount == 3) begin
            req = 4'b1111 & ~(4'b0001 << curIdx);
         end else begin
            req = 4'b1111;
         end
         @(posedge clk);
         #1;
         if (gnt_valid) begin
            if (!prevValid) begin
               curIdx = expIdx.pop_front();
               checkValue($sformatf("rotation_idx%0d", grantsSeen), int'(gnt_idx), curIdx);
               checkValue($sformatf("rotation_gnt%0d", grantsSeen), int'(gnt), 1 << curIdx);
               if (grantsSeen > 0) begin
                  checkValue($sformatf("rotation_gap%0d", grantsSeen), gapCount, 1);
               end
               grantsSeen++;
               holdCount = 1;
            end else begin
               holdCount++;
            end
            gapCount = 0;
         end else begin
            holdCount = 0;
            gapCount++;
         end
         prevValid = gnt_valid;
      end
      checkValue("rotation_grants_remaining", expIdx.size(), 0);

      // Async reset in the middle of a grant, then re-arbitration from ptr 0.
      resetDut(4'b0000);
      applyStimulus("midreset_grant", 4'b1000, ex(4'b1000, 2'd3, 1'b0));
      applyStimulus("midreset_hold", 4'b1000, ex(4'b1000, 2'd3, 1'b0));
      #2;
      rst_n = 1'b0;
      req   = 4'b1001;
      #1;
      checkOutput("midreset_async_clear", ex(4'b0000, 2'd0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_regrant", ex(4'b0001, 2'd0, 1'b0));

      // Long hold with two constant requesters.
      resetDut(4'b0000);
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c <= 14; c++) begin
         p = (c - 1) % 5;
         n = (c - 1) / 5;
         if (p < 4) begin
            g = (n % 2 == 0) ? 4'b0001 : 4'b0010;
            applyStimulus($sformatf("timeout_c%0d", c), 4'b0011, ex(g, (n % 2 == 0) ? 2'd0 : 2'd1, 1'b0));
         end else begin
            applyStimulus($sformatf("timeout_c%0d", c), 4'b0011, ex(4'b0000, 2'd0, 1'b1));
         end
      end
`else
      for (int c = 1; c <= 120; c++) begin
         applyStimulus($sformatf("longhold_c%0d", c), 4'b0011, ex(4'b0001, 2'd0, 1'b0));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
